alu_pipe: RTL

Parametrised, two-stage pipelined ALU with valid/ready handshakes on input and output. Adds Negative, Carry and Overflow flags and an unsigned set-less-than (F=011) to the existing F encoding, which keeps Zero. Completed results are counted. It sits between the datapath issue logic and writeback, and it is driven by the same vector-driven bench style as the existing 32-bit ALU.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_if.sv | 35 +++
 rtl/alu_core.sv | 59 +++++
 rtl/alu_pipe.sv | 97 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   ALU_WIDTH   - default operand/result width
//   alu_func_e  - 3-bit function select encodings
//   alu_flags_t - result flag bundle (Zero, Negative, Carry, Overflow)
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    F_AND  = 3'b000,
    F_OR   = 3'b001,
    F_ADD  = 3'b010,
    F_SLTU = 3'b011,
    F_ANDN = 3'b100,
    F_ORN  = 3'b101,
    F_SUB  = 3'b110,
    F_SLT  = 3'b111
  } alu_func_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// alu_if: operation/result handshake bundle for alu_pipe.
//   in_valid/in_ready   - operation offer/accept
//   A, B, F             - operands and function select
//   out_valid/out_ready - result present/taken
//   Y, Zero, Negative, Carry, Overflow - result and flags
// master: issue side (drives operations, consumes results)
// slave : the ALU pipeline
interface alu_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       F;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             Zero;
  logic             Negative;
  logic             Carry;
  logic             Overflow;

  modport master (
    output in_valid, A, B, F, out_ready,
    input  in_ready, out_valid, Y, Zero, Negative, Carry, Overflow
  );

  modport slave (
    input  in_valid, A, B, F, out_ready,
    output in_ready, out_valid, Y, Zero, Negative, Carry, Overflow
  );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU.
//   a, b  - operands (WIDTH bits)
//   f     - function select (alu_func_e)
//   y     - result
//   flags - Zero/Negative from y; Carry/Overflow only for ADD and SUB
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_func_e        f,
  output logic [WIDTH-1:0] y,
  output alu_flags_t       flags
);

  logic                    is_sub;
  logic [WIDTH-1:0]        b_op;
  logic [WIDTH:0]          sum_ext;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    lt_s;
  logic                    lt_u;
  logic                    add_ovf;

  // Subtraction shares the adder: A + ~B + 1, so Carry=1 means no borrow.
  assign is_sub  = (f == F_SUB);
  assign b_op    = is_sub ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};

  // Signed overflow: adder inputs share a sign that the sum does not.
  assign add_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) & (sum_ext[WIDTH-1] != a[WIDTH-1]);

  assign a_s  = a;
  assign b_s  = b;
  assign lt_s = (a_s < b_s);
  assign lt_u = (a < b);

  always_comb begin
    y     = '0;
    flags = '0;
    unique case (f)
      F_AND:  y = a & b;
      F_OR:   y = a | b;
      F_ANDN: y = a & ~b;
      F_ORN:  y = a | ~b;
      F_SLTU: y = {{(WIDTH-1){1'b0}}, lt_u};
      F_SLT:  y = {{(WIDTH-1){1'b0}}, lt_s};
      F_ADD, F_SUB: begin
        y              = sum_ext[WIDTH-1:0];
        flags.carry    = sum_ext[WIDTH];
        flags.overflow = add_ovf;
      end
      default: y = '0;
    endcase
    flags.zero     = (y == '0);
    flags.negative = y[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides.
//   Clock    - rising-edge clock
//   Reset    - asynchronous active-high; flushes the pipe and clears all state
//   bus      - alu_if.slave: operation in, result + flags out
//   op_count - completed output transfers, wraps at 2^CNTW
// Stage 1 holds the accepted operands; stage 2 holds the computed result.
// in_ready depends combinationally on out_ready through the stage-2 advance.
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNTW  = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  alu_if.slave            bus,
  output logic [CNTW-1:0] op_count
);

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  alu_func_e        f_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] y_p2;
  alu_flags_t       flags_p2;

  logic             load1;
  logic             load2;
  logic             xfer;
  logic [WIDTH-1:0] y_core;
  alu_flags_t       flags_core;

  assign load2        = vld_p1 & (~vld_p2 | bus.out_ready);
  assign bus.in_ready = ~Reset & (~vld_p1 | load2);
  assign load1        = bus.in_valid & bus.in_ready;
  assign xfer         = vld_p2 & bus.out_ready;

  // ---- stage 1: capture operands on acceptance ----
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      f_p1   <= F_AND;
    end else begin
      if (load1) begin
        vld_p1 <= 1'b1;
        a_p1   <= bus.A;
        b_p1   <= bus.B;
        f_p1   <= alu_func_e'(bus.F);
      end else if (load2) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (a_p1),
    .b     (b_p1),
    .f     (f_p1),
    .y     (y_core),
    .flags (flags_core)
  );

  // ---- stage 2: result register, held while the consumer stalls ----
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vld_p2   <= 1'b0;
      y_p2     <= '0;
      flags_p2 <= '0;
    end else begin
      if (load2) begin
        vld_p2   <= 1'b1;
        y_p2     <= y_core;
        flags_p2 <= flags_core;
      end else if (xfer) begin
        vld_p2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_count <= '0;
    end else if (xfer) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.Y         = y_p2;
  assign bus.Zero      = flags_p2.zero;
  assign bus.Negative  = flags_p2.negative;
  assign bus.Carry     = flags_p2.carry;
  assign bus.Overflow  = flags_p2.overflow;

endmodule
